// File: rtl/seg7_reader.sv
// Recovers hex digits from a multiplexed, active-low 7-segment display bus.
// Each digit is captured once per stable interval; a frame pulse marks a full scan.
module seg7_reader #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [6:0]           seg_i,
   input  logic [NDIG-1:0]      an_i,
   input  logic                 clr_i,
   output logic [4*NDIG-1:0]    value_o,
   output logic [NDIG-1:0]      err_o,
   output logic                 frame_valid_o
);

   typedef enum logic {SETTLE, HOLD} state_t;

   localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYC);
   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 2);

   logic [6:0]        seg_q;
   logic [NDIG-1:0]   an_q;
   logic [7:0]        cnt;
   state_t            state;
   logic [NDIG-1:0]   seen;

   logic              chg;
   logic              capture;
   logic              qual;
   logic [4:0]        glyph;
   logic [4*NDIG-1:0] value_nxt;
   logic [NDIG-1:0]   err_nxt;
   logic [NDIG-1:0]   seen_nxt;

   // Returns {legal, nibble}; anything outside the sixteen hex glyphs is illegal.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      case (seg)
         7'h40:   return {1'b1, 4'h0};
         7'h79:   return {1'b1, 4'h1};
         7'h24:   return {1'b1, 4'h2};
         7'h30:   return {1'b1, 4'h3};
         7'h19:   return {1'b1, 4'h4};
         7'h12:   return {1'b1, 4'h5};
         7'h02:   return {1'b1, 4'h6};
         7'h78:   return {1'b1, 4'h7};
         7'h00:   return {1'b1, 4'h8};
         7'h18:   return {1'b1, 4'h9};
         7'h08:   return {1'b1, 4'hA};
         7'h03:   return {1'b1, 4'hB};
         7'h46:   return {1'b1, 4'hC};
         7'h21:   return {1'b1, 4'hD};
         7'h06:   return {1'b1, 4'hE};
         7'h0E:   return {1'b1, 4'hF};
         default: return 5'b0;
      endcase
   endfunction

   // A change is the edge on which the input register takes a new pattern.
   assign chg     = ({an_i, seg_i} != {an_q, seg_q});
   assign capture = (state == SETTLE) && !chg && (cnt == CNT_LAST);
   assign qual    = $onehot(~an_q);
   assign glyph   = decode_glyph(seg_q);

   always_comb begin
      value_nxt = value_o;
      err_nxt   = err_o;
      seen_nxt  = (&seen) ? '0 : seen;
      if (capture && qual) begin
         for (int k = 0; k < NDIG; k++) begin
            if (!an_q[k]) begin
               seen_nxt[k] = 1'b1;
               if (glyph[4]) begin
                  value_nxt[4*k +: 4] = glyph[3:0];
                  err_nxt[k]          = 1'b0;
               end else begin
                  err_nxt[k] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q <= 7'h7F;
         an_q  <= '1;
      end else begin
         seg_q <= seg_i;
         an_q  <= an_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt           <= '0;
         state         <= SETTLE;
         seen          <= '0;
         value_o       <= '0;
         err_o         <= '0;
         frame_valid_o <= 1'b0;
      end else if (clr_i) begin
         cnt           <= '0;
         state         <= SETTLE;
         seen          <= '0;
         value_o       <= '0;
         err_o         <= '0;
         frame_valid_o <= 1'b0;
      end else begin
         frame_valid_o <= &seen;
         seen          <= seen_nxt;
         value_o       <= value_nxt;
         err_o         <= err_nxt;
         if (chg) begin
            cnt   <= '0;
            state <= SETTLE;
         end else begin
            if (cnt != CNT_MAX)
               cnt <= cnt + 8'd1;
            if (capture)
               state <= HOLD;
         end
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: stimulus queues expected output events,
// a monitor pops and compares each event the DUT presents.
module tb_seg7_reader;

   localparam int NDIG = 4;
   localparam int S    = 4;

   logic                clk = 1'b0;
   logic                rst_ni;
   logic [6:0]          seg_i;
   logic [NDIG-1:0]     an_i;
   logic                clr_i;
   logic [4*NDIG-1:0]   value_o;
   logic [NDIG-1:0]     err_o;
   logic                frame_valid_o;

   seg7_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .seg_i         (seg_i),
      .an_i          (an_i),
      .clr_i         (clr_i),
      .value_o       (value_o),
      .err_o         (err_o),
      .frame_valid_o (frame_valid_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] val;
      logic [3:0]  err;
      logic        fr;
      int          at;
   } ev_t;

   ev_t  expq[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   mon_en = 0;
   logic [19:0] prev = '0;

   task automatic expect_ev(input logic [15:0] v, input logic [3:0] e,
                            input logic f, input int at);
      ev_t x;
      x.val = v; x.err = e; x.fr = f; x.at = at;
      expq.push_back(x);
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_i  = an;
      seg_i = seg;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: any change of value/err or a frame pulse is an output event.
   initial begin
      ev_t x;
      forever begin
         @(negedge clk);
         if (mon_en && (({value_o, err_o} !== prev) || frame_valid_o === 1'b1)) begin
            n_vec++;
            if (expq.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: got value=%h err=%b frame=%b cyc=%0d, required no event",
                        value_o, err_o, frame_valid_o, cyc);
            end else begin
               x = expq.pop_front();
               if (value_o !== x.val || err_o !== x.err || frame_valid_o !== x.fr || cyc != x.at) begin
                  n_bad++;
                  $display("FAIL event: got value=%h err=%b frame=%b cyc=%0d, required value=%h err=%b frame=%b cyc=%0d",
                           value_o, err_o, frame_valid_o, cyc, x.val, x.err, x.fr, x.at);
               end
            end
         end
         prev = {value_o, err_o};
      end
   end

   initial begin
      rst_ni = 1'b0;
      clr_i  = 1'b0;
      an_i   = 4'hF;
      seg_i  = 7'h7F;
      repeat (3) @(negedge clk);
      n_vec++;
      if (value_o !== 16'h0 || err_o !== 4'h0 || frame_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got value=%h err=%b frame=%b, required 0000 0000 0",
                  value_o, err_o, frame_valid_o);
      end
      rst_ni = 1'b1;
      mon_en = 1;
      drive(4'hF, 7'h7F, 3);

      // Long hold of '3' on digit 0: one capture, S-1 edges after first sample
      expect_ev(16'h0003, 4'h0, 1'b0, cyc + S);
      drive(4'hE, 7'h30, 10);

      // Full scan 2,4,6,C then a frame pulse
      expect_ev(16'h0002, 4'h0, 1'b0, cyc + S);
      drive(4'hE, 7'h24, 6);
      expect_ev(16'h0042, 4'h0, 1'b0, cyc + S);
      drive(4'hD, 7'h19, 6);
      expect_ev(16'h0642, 4'h0, 1'b0, cyc + S);
      drive(4'hB, 7'h02, 6);
      expect_ev(16'hC642, 4'h0, 1'b0, cyc + S);
      expect_ev(16'hC642, 4'h0, 1'b1, cyc + S + 1);
      drive(4'h7, 7'h46, 6);

      // Blank glyph flags error and keeps the nibble; a legal F clears it
      expect_ev(16'hC642, 4'b0010, 1'b0, cyc + S);
      drive(4'hD, 7'h7F, 6);
      expect_ev(16'hC6F2, 4'h0, 1'b0, cyc + S);
      drive(4'hD, 7'h0E, 6);

      // Short glitch to '8' inside a stable '1' on digit 2
      expect_ev(16'hC1F2, 4'h0, 1'b0, cyc + S);
      drive(4'hB, 7'h79, 6);
      drive(4'hB, 7'h00, 2);
      drive(4'hB, 7'h79, 6);

      // Multi-select and blanked enables must not touch anything
      drive(4'hC, 7'h40, 8);
      drive(4'hF, 7'h40, 8);
      // seen still holds digits 1,2: finishing 0 and 3 completes a frame
      expect_ev(16'hC1F0, 4'h0, 1'b0, cyc + S);
      drive(4'hE, 7'h40, 6);
      expect_ev(16'h01F0, 4'h0, 1'b0, cyc + S);
      expect_ev(16'h01F0, 4'h0, 1'b1, cyc + S + 1);
      drive(4'h7, 7'h40, 6);

      // Clear on the capture edge wins, then reset mid-settle
      expect_ev(16'h0000, 4'h0, 1'b0, cyc + S);
      drive(4'hE, 7'h12, 3);
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
      @(negedge clk);
      rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (value_o !== 16'h0 || err_o !== 4'h0 || frame_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_then_reset: got value=%h err=%b frame=%b, required 0000 0000 0",
                  value_o, err_o, frame_valid_o);
      end
      // Qualification starts afresh after release
      expect_ev(16'h0005, 4'h0, 1'b0, cyc + S);
      rst_ni = 1'b1;
      repeat (8) @(negedge clk);

      n_vec++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events: got %0d events still pending, required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of multiplexed digits.
REQ-002 SHALL have parameter STABLE_CYC, default 4, legal range 2..255: consecutive cycles a pattern must hold before capture.
REQ-003 SHALL have port clk_i  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port seg_i  input  7: active-low segment lines; bit 6..0 = segment g..a.
REQ-006 SHALL have port an_i  input  NDIG: active-low digit enables; bit k selects digit k.
REQ-007 SHALL have port clr_i  input  1: synchronous clear of captured data.
REQ-008 SHALL have port value_o  output  4*NDIG: recovered hex digits; digit k at bits 4k+3..4k.
REQ-009 SHALL have port err_o  output  NDIG: bit k set when the last qualified pattern on digit k was not a legal hex glyph.
REQ-010 SHALL have port frame_valid_o  output  1: one-cycle pulse when every digit has been captured since the last frame.

Function
REQ-011 SHALL register seg_i and an_i into an input register (seg_q, an_q) every cycle; all decisions use seg_q/an_q.
REQ-012 SHALL keep a stability counter: it resets to 0 when {an_q,seg_q} differs from its value in the previous cycle, and otherwise increments, saturating at STABLE_CYC.
REQ-013 SHALL implement FSM SETTLE -> HOLD -> SETTLE: SETTLE while counter < STABLE_CYC-1; on the edge the counter reaches STABLE_CYC-1 with no change -> capture, go HOLD; HOLD -> SETTLE on any {an_q,seg_q} change.
REQ-014 SHALL capture at most once per stable interval; a pattern held indefinitely yields one capture.
REQ-015 SHALL qualify a capture only if an_q has exactly one bit at 0; all-ones (blanked) or multi-zero an_q causes no update, although the FSM still enters HOLD.
REQ-016 SHALL decode seg_q (hex, g..a) as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-017 SHALL, on a qualified capture with a legal glyph, write the nibble to digit k, clear err_o[k], and set seen[k].
REQ-018 SHALL, on a qualified capture with any other glyph (including 7F blank and 3F dash), leave nibble k unchanged, set err_o[k], and set seen[k].
REQ-019 SHALL pulse frame_valid_o for one cycle on the edge after seen becomes all ones, and clear seen on that same edge; a capture on that same edge sets its seen bit after the clear.
REQ-020 SHALL give clr_i priority over capture: on clr_i=1, value_o, err_o and seen go to 0, the counter goes to 0, the FSM goes to SETTLE, and frame_valid_o goes to 0.
REQ-021 SHALL have a latency such that a new pattern present at seg_i/an_i before edge N appears on value_o/err_o after edge N+STABLE_CYC-1, provided it is held through that edge.
REQ-022 SHALL produce no spurious capture from a glitch shorter than STABLE_CYC cycles.

Reset
REQ-023 SHALL, while rst_ni=0, asynchronously force seg_q=7F, an_q=all ones, counter=0, FSM=SETTLE, seen=0, value_o=0, err_o=0, frame_valid_o=0.
REQ-024 SHALL abandon any in-progress settle on reset assertion mid-operation, and begin qualifying afresh after release.

Verification
REQ-025 Hold an_i=1110, seg_i=30 for 10 cycles -> value_o[3:0]=3 exactly STABLE_CYC-1 edges after first sample, err_o[0]=0, one capture only.
REQ-026 Scan digits 0..3 with 24,19,02,46 (6 cycles each) -> frame_valid_o single pulse, value_o=16'hC642, err_o=0.
REQ-027 Hold an_i=1101, seg_i=7F for 6 cycles -> err_o[1]=1, value_o[7:4] unchanged; then seg_i=0E -> value_o[7:4]=F, err_o[1]=0.
REQ-028 Apply 2-cycle glitch seg_i=00 amid a stable 79 on digit 2 -> value_o[11:8] stays 1, no new capture.
REQ-029 Apply an_i=1100 or an_i=1111 for 8 cycles -> no change to value_o, err_o or seen.
REQ-030 Assert clr_i on the same edge as a capture, then assert rst_ni=0 mid-settle -> all outputs 0, no frame_valid_o pulse.
